// File: rtl/sop_edge_monitor.sv
// rtl/sop_edge_monitor.sv - synchronizes a complementary pair, glitch-filters it, emits edge pulses and counts
module sop_edge_monitor #(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_in,
    input  logic             out_n_in,
    input  logic             clear,
    output logic             filt_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count,
    output logic             fault
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] QTARGET = QW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        QUAL_HIGH = 2'd1,
        HIGH      = 2'd2,
        QUAL_LOW  = 2'd3
    } state_e;

    state_e           state_q;
    logic [QW-1:0]    qcnt_q;
    logic             out_s1_q, out_s2_q, out_n_s1_q, out_n_s2_q;
    logic             filt_q, rise_q, fall_q, fault_q;
    logic [CNT_W-1:0] rise_cnt_q, fall_cnt_q;

    logic          pair_valid, want_high, want_low, rise_ev, fall_ev;
    logic [QW-1:0] qcnt_inc;

    // The complement chain resets to 1 so the pair looks valid (low) right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_s1_q   <= 1'b0;
            out_s2_q   <= 1'b0;
            out_n_s1_q <= 1'b1;
            out_n_s2_q <= 1'b1;
        end else begin
            out_s1_q   <= out_in;
            out_s2_q   <= out_s1_q;
            out_n_s1_q <= out_n_in;
            out_n_s2_q <= out_n_s1_q;
        end
    end

    always_comb begin
        pair_valid = out_s2_q != out_n_s2_q;
        want_high  = pair_valid && out_s2_q;
        want_low   = pair_valid && !out_s2_q;
        qcnt_inc   = qcnt_q + QW'(1);
        rise_ev    = want_high && ((state_q == LOW && STABLE_CYCLES == 1) ||
                                   (state_q == QUAL_HIGH && qcnt_inc == QTARGET));
        fall_ev    = want_low && ((state_q == HIGH && STABLE_CYCLES == 1) ||
                                  (state_q == QUAL_LOW && qcnt_inc == QTARGET));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOW;
            qcnt_q  <= '0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= rise_ev;
            fall_q <= fall_ev;
            if (rise_ev) begin
                state_q <= HIGH;
                qcnt_q  <= '0;
                filt_q  <= 1'b1;
            end else if (fall_ev) begin
                state_q <= LOW;
                qcnt_q  <= '0;
                filt_q  <= 1'b0;
            end else begin
                case (state_q)
                    LOW: if (want_high) begin
                        state_q <= QUAL_HIGH;
                        qcnt_q  <= QW'(1);
                    end
                    QUAL_HIGH: if (want_high) begin
                        qcnt_q <= qcnt_inc;
                    end else begin
                        state_q <= LOW;
                        qcnt_q  <= '0;
                    end
                    HIGH: if (want_low) begin
                        state_q <= QUAL_LOW;
                        qcnt_q  <= QW'(1);
                    end
                    QUAL_LOW: if (want_low) begin
                        qcnt_q <= qcnt_inc;
                    end else begin
                        state_q <= HIGH;
                        qcnt_q  <= '0;
                    end
                    default: begin
                        state_q <= LOW;
                        qcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Clear beats a same-cycle count event, but a same-cycle invalid pair beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            if (clear) begin
                rise_cnt_q <= '0;
                fall_cnt_q <= '0;
            end else begin
                if (rise_ev && rise_cnt_q != '1) rise_cnt_q <= rise_cnt_q + CNT_W'(1);
                if (fall_ev && fall_cnt_q != '1) fall_cnt_q <= fall_cnt_q + CNT_W'(1);
            end
            fault_q <= !pair_valid || (fault_q && !clear);
        end
    end

    assign filt_out   = filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_count = rise_cnt_q;
    assign fall_count = fall_cnt_q;
    assign fault      = fault_q;

endmodule
